// File: rtl/exp_1x1_kernel_wr_ctrl.sv
// ---------------------------------------------------------------------------
// exp_1x1_kernel_wr_ctrl
//
// Write-side controller for the expand 1x1 kernel RAM. It follows the expand
// 1x1 write-config stage. It takes packed kernel words over a valid/ready
// handshake and turns each accepted word into one sequential RAM write,
// issued one cycle after the handshake. It also flags the end of each layer
// and the end of the fire.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               fire-start pulse (honoured only in IDLE)
//   exp_1x1_en_i          expand 1x1 enable from the config stage
//   wr_addr_per_fire_i    last write address of the fire
//   wr_addr_per_layr_i    last per-layer index
//   ker_data_i/_valid_i   kernel word stream in
//   ker_ready_o           high only while loading
//   ram_wr_en_o/_addr_o/_data_o   kernel RAM write port
//   layr_done_o           pulse with the last write of each layer
//   fire_done_o           pulse at fire completion
//   busy_o                high from the cycle after start until DONE exits
// ---------------------------------------------------------------------------
module exp_1x1_kernel_wr_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int LAYR_W = 7
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              exp_1x1_en_i,
  input  logic [ADDR_W-1:0] wr_addr_per_fire_i,
  input  logic [LAYR_W-1:0] wr_addr_per_layr_i,
  input  logic [DATA_W-1:0] ker_data_i,
  input  logic              ker_valid_i,
  output logic              ker_ready_o,
  output logic              ram_wr_en_o,
  output logic [ADDR_W-1:0] ram_wr_addr_o,
  output logic [DATA_W-1:0] ram_wr_data_o,
  output logic              layr_done_o,
  output logic              fire_done_o,
  output logic              busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CFG  = 2'd1,
    S_LOAD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   fire_cnt_q,  fire_cnt_d;
  logic [LAYR_W-1:0]   layr_cnt_q,  layr_cnt_d;
  logic                wr_en_q,     wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q,   wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q,   wr_data_d;
  logic                layr_done_q, layr_done_d;
  logic                fire_done_q, fire_done_d;

  logic beat;
  logic last_beat;
  logic layr_wrap;

  // Ready is decoded straight from state, so an asynchronous reset drops it
  // in the same instant the state register clears.
  assign ker_ready_o = (state_q == S_LOAD);
  assign busy_o      = (state_q != S_IDLE);

  assign beat      = ker_ready_o & ker_valid_i;
  assign last_beat = (fire_cnt_q == wr_addr_per_fire_i);
  assign layr_wrap = (layr_cnt_q == wr_addr_per_layr_i);

  always_comb begin
    state_d     = state_q;
    fire_cnt_d  = fire_cnt_q;
    layr_cnt_d  = layr_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    layr_done_d = 1'b0;
    fire_done_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_CFG;
      end
      S_CFG: begin
        // Config-stage outputs become valid here; a disabled fire completes
        // without writing anything.
        fire_cnt_d = '0;
        layr_cnt_d = '0;
        if (exp_1x1_en_i) begin
          state_d = S_LOAD;
        end else begin
          state_d     = S_DONE;
          fire_done_d = 1'b1;
        end
      end
      S_LOAD: begin
        if (beat) begin
          wr_en_d     = 1'b1;
          wr_addr_d   = fire_cnt_q;
          wr_data_d   = ker_data_i;
          fire_cnt_d  = fire_cnt_q + ADDR_W'(1);
          layr_cnt_d  = layr_wrap ? '0 : layr_cnt_q + LAYR_W'(1);
          // The final word closes a partial layer too.
          layr_done_d = layr_wrap | last_beat;
          if (last_beat) begin
            fire_done_d = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      fire_cnt_q  <= '0;
      layr_cnt_q  <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      layr_done_q <= 1'b0;
      fire_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fire_cnt_q  <= fire_cnt_d;
      layr_cnt_q  <= layr_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      layr_done_q <= layr_done_d;
      fire_done_q <= fire_done_d;
    end
  end

  assign ram_wr_en_o   = wr_en_q;
  assign ram_wr_addr_o = wr_addr_q;
  assign ram_wr_data_o = wr_data_q;
  assign layr_done_o   = layr_done_q;
  assign fire_done_o   = fire_done_q;

endmodule
